// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM states, parity modes and
// the three-sample majority vote.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push into a full FIFO is accepted only
// when a pop happens in the same cycle; a pop on empty is ignored.
module uart_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap on natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_stream.sv
// UART receiver: 2-flop synchroniser, runtime-divided oversample tick, majority-vote bit
// sampling, parity/stop checking with error pulses, and a valid/ready output FIFO.
module uart_rx_stream
    import uart_pkg::*;
#(
    parameter int BITS_PER_WORD = 8,
    parameter int W_DIV         = 16,
    parameter int OVERSAMPLE    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    input  logic [W_DIV-1:0]         cfg_div,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop2,
    output logic [BITS_PER_WORD-1:0] m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     err_frame,
    output logic                     err_parity,
    output logic                     err_overrun,
    output logic                     busy
);

    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(BITS_PER_WORD + 1);
    localparam logic [SW-1:0]  S_V0    = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0]  S_V1    = SW'(OVERSAMPLE/2);
    localparam logic [SW-1:0]  S_V2    = SW'(OVERSAMPLE/2 + 1);
    localparam logic [SW-1:0]  S_END   = SW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] B_LAST  = BCW'(BITS_PER_WORD - 1);

    state_t                   state, state_nxt;
    logic                     rx_m, rx_s, armed;
    logic [W_DIV-1:0]         div_q, tick_cnt;
    logic [1:0]               par_q;
    logic                     stop2_q;
    logic [SW-1:0]            s_cnt;
    logic [BCW-1:0]           bit_cnt;
    logic                     v0, v1, vote, tick, vote_now, bit_end, last_stop;
    logic [BITS_PER_WORD-1:0] shreg, push_data_q;
    logic                     perr, ferr, push_q;
    logic                     dec_frame, dec_parity, dec_push;
    logic                     fifo_full, fifo_empty, fifo_pop;
    logic [BITS_PER_WORD-1:0] fifo_head;

    assign tick      = (state != IDLE) && (tick_cnt == div_q);
    assign vote      = majority3(v0, v1, rx_s);
    assign vote_now  = tick && (s_cnt == S_V2);
    assign bit_end   = tick && (s_cnt == S_END);
    assign last_stop = (bit_cnt == BCW'(stop2_q));
    assign busy      = (state != IDLE);

    // The frame is resolved at the last stop bit's third sample, leaving the rest of
    // that bit in IDLE so an immediately following start edge is caught.
    always_comb begin
        state_nxt  = state;
        dec_frame  = 1'b0;
        dec_parity = 1'b0;
        dec_push   = 1'b0;
        unique case (state)
            IDLE:   if (armed && !rx_s) state_nxt = START;
            START: begin
                if (vote_now && vote)
                    state_nxt = IDLE;
                else if (bit_end)
                    state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && bit_cnt == B_LAST)
                    state_nxt = (par_q == PAR_EVEN || par_q == PAR_ODD) ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_nxt = STOP;
            STOP: begin
                if (vote_now && last_stop) begin
                    if (ferr || !vote) begin
                        dec_frame = 1'b1;
                        state_nxt = BREAK;
                    end else if (perr) begin
                        dec_parity = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        dec_push  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            BREAK:  if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            armed       <= 1'b0;
            state       <= IDLE;
            div_q       <= '0;
            par_q       <= PAR_NONE;
            stop2_q     <= 1'b0;
            tick_cnt    <= '0;
            s_cnt       <= '0;
            bit_cnt     <= '0;
            v0          <= 1'b1;
            v1          <= 1'b1;
            shreg       <= '0;
            perr        <= 1'b0;
            ferr        <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            err_frame   <= 1'b0;
            err_parity  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            rx_m        <= rx;
            rx_s        <= rx_m;
            state       <= state_nxt;
            push_q      <= dec_push;
            err_frame   <= dec_frame;
            err_parity  <= dec_parity;
            err_overrun <= push_q && fifo_full && !fifo_pop;
            if (dec_push)
                push_data_q <= shreg;
            // A start is only honoured after the line has been seen idle since reset
            if (rx_s)
                armed <= 1'b1;

            if (state == IDLE) begin
                tick_cnt <= '0;
                s_cnt    <= '0;
                bit_cnt  <= '0;
                perr     <= 1'b0;
                ferr     <= 1'b0;
                if (state_nxt != IDLE) begin
                    div_q   <= cfg_div;
                    par_q   <= cfg_parity;
                    stop2_q <= cfg_stop2;
                end
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + W_DIV'(1);
                if (tick) begin
                    s_cnt <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
                    if (s_cnt == S_V0) v0 <= rx_s;
                    if (s_cnt == S_V1) v1 <= rx_s;
                end
                if (vote_now) begin
                    unique case (state)
                        DATA:    shreg <= {vote, shreg[BITS_PER_WORD-1:1]};
                        PARITY:  perr  <= vote ^ (^shreg) ^ (par_q == PAR_ODD);
                        STOP:    if (!vote) ferr <= 1'b1;
                        default: ;
                    endcase
                end
                if (bit_end) begin
                    if ((state == DATA && bit_cnt != B_LAST) || state == STOP)
                        bit_cnt <= bit_cnt + BCW'(1);
                    else
                        bit_cnt <= '0;
                end
            end
        end
    end

    assign fifo_pop = m_ready && !fifo_empty;

    uart_sync_fifo #(
        .W     (BITS_PER_WORD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (push_data_q),
        .pop       (m_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream: reset, 8N1 receive, parity, break, glitch rejection
// and FIFO overrun with and without a same-cycle pop.
module tb_uart_rx_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b0;
    logic [15:0] cfg_div = 16'd0;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        err_frame, err_parity, err_overrun, busy;

    int vectors = 0;
    int miscompares = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0;

    always #5 clk = ~clk;

    uart_rx_stream #(
        .BITS_PER_WORD (8),
        .W_DIV         (16),
        .OVERSAMPLE    (16),
        .FIFO_DEPTH    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .cfg_div     (cfg_div),
        .cfg_parity  (cfg_parity),
        .cfg_stop2   (cfg_stop2),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .err_frame   (err_frame),
        .err_parity  (err_parity),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always @(negedge clk) begin
        if (err_frame)   n_ferr++;
        if (err_parity)  n_perr++;
        if (err_overrun) n_ovr++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit flip_par, input logic stop_val);
        int  blen;
        logic p;
        blen = (int'(cfg_div) + 1) * 16;
        rx = 1'b0;
        wait_clks(blen);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(blen);
        end
        if (cfg_parity == 2'b01 || cfg_parity == 2'b10) begin
            p  = (^d) ^ (cfg_parity == 2'b10) ^ flip_par;
            rx = p;
            wait_clks(blen);
        end
        rx = stop_val;
        wait_clks(cfg_stop2 ? 2 * blen : blen);
    endtask

    task automatic pop_word(output logic [7:0] d, output bit got);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (m_valid) got = 1'b1;
        end
        d = m_data;
        if (got) begin
            m_ready = 1'b1;
            @(negedge clk);
            m_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b0;
        wait_clks(3);
        vectors++;
        if ({m_valid, m_data, err_frame, err_parity, err_overrun, busy} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got valid=%b data=%h ef=%b ep=%b eo=%b busy=%b want all 0",
                     m_valid, m_data, err_frame, err_parity, err_overrun, busy);
        end
        rx  = 1'b1;
        rst = 1'b0;
        wait_clks(5);
        vectors++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0 0", busy, m_valid);
        end
    endtask

    task automatic test_8n1;
        int cyc;
        cfg_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        cyc = 0;
        fork
            send_frame(8'hA5, 1'b0, 1'b1);
            while (!m_valid && cyc < 900) begin
                @(negedge clk);
                cyc++;
            end
        join
        vectors++;
        if (cyc < 576 || cyc > 640) begin
            miscompares++;
            $display("FAIL 8n1_latency got %0d clocks want 576..640", cyc);
        end
        vectors++;
        if (m_data !== 8'hA5 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL 8n1_data got %h valid=%b want a5 valid=1", m_data, m_valid);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        vectors++;
        if (m_valid !== 1'b0 || m_data !== 8'h00) begin
            miscompares++;
            $display("FAIL 8n1_pop got valid=%b data=%h want 0 00", m_valid, m_data);
        end
    endtask

    task automatic test_parity;
        int p0, f0;
        logic [7:0] d;
        bit got;
        p0 = n_perr; f0 = n_ferr;
        cfg_div = 16'd0; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_clks(20);
        vectors++;
        if (n_perr - p0 !== 1 || n_ferr - f0 !== 0) begin
            miscompares++;
            $display("FAIL parity_err got perr=%0d ferr=%0d want 1 0", n_perr - p0, n_ferr - f0);
        end
        pop_word(d, got);
        vectors++;
        if (!got || d !== 8'h3C) begin
            miscompares++;
            $display("FAIL parity_word got %h (present=%b) want 3c", d, got);
        end
        wait_clks(2);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL parity_no_push got valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_break;
        int p0, f0;
        logic [7:0] d;
        bit got;
        p0 = n_perr; f0 = n_ferr;
        cfg_div = 16'd1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0);
        rx = 1'b0;
        wait_clks(40 * 32);
        vectors++;
        if (n_ferr - f0 !== 1 || n_perr - p0 !== 0) begin
            miscompares++;
            $display("FAIL break_ferr got ferr=%0d perr=%0d want 1 0", n_ferr - f0, n_perr - p0);
        end
        vectors++;
        if (busy !== 1'b1 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL break_busy got busy=%b valid=%b want 1 0", busy, m_valid);
        end
        rx = 1'b1;
        wait_clks(10);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL break_release got busy=%b want 0", busy);
        end
        send_frame(8'h12, 1'b0, 1'b1);
        pop_word(d, got);
        vectors++;
        if (!got || d !== 8'h12) begin
            miscompares++;
            $display("FAIL break_next_word got %h (present=%b) want 12", d, got);
        end
    endtask

    task automatic test_glitch;
        int p0, f0;
        p0 = n_perr; f0 = n_ferr;
        cfg_div = 16'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        rx = 1'b0;
        wait_clks(5);
        rx = 1'b1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_start got busy=%b want 1", busy);
        end
        wait_clks(100);
        vectors++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || n_ferr != f0 || n_perr != p0) begin
            miscompares++;
            $display("FAIL glitch_reject got busy=%b valid=%b ferr=%0d perr=%0d want 0 0 0 0",
                     busy, m_valid, n_ferr - f0, n_perr - p0);
        end
    endtask

    task automatic test_overrun;
        int o0;
        logic [7:0] d;
        bit got;
        o0 = n_ovr;
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++)
            send_frame(8'(i), 1'b0, 1'b1);
        wait_clks(20);
        vectors++;
        if (n_ovr - o0 !== 1) begin
            miscompares++;
            $display("FAIL overrun_count got %0d want 1", n_ovr - o0);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_word(d, got);
            vectors++;
            if (!got || d !== 8'(i)) begin
                miscompares++;
                $display("FAIL overrun_drain%0d got %h (present=%b) want %h", i, d, got, 8'(i));
            end
        end
        wait_clks(2);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_empty got valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_back_to_back;
        int o0;
        logic [7:0] d;
        bit got;
        o0 = n_ovr;
        cfg_div = 16'd0; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        for (int i = 1; i <= 4; i++)
            send_frame(8'(i), 1'b0, 1'b1);
        // 5th push lands on the posedge after clock 157 of the frame; pop in that same cycle
        fork
            send_frame(8'h05, 1'b0, 1'b1);
            begin
                wait_clks(157);
                m_ready = 1'b1;
                @(negedge clk);
                m_ready = 1'b0;
            end
        join
        wait_clks(20);
        vectors++;
        if (n_ovr - o0 !== 0) begin
            miscompares++;
            $display("FAIL b2b_no_overrun got %0d want 0", n_ovr - o0);
        end
        for (int i = 2; i <= 5; i++) begin
            pop_word(d, got);
            vectors++;
            if (!got || d !== 8'(i)) begin
                miscompares++;
                $display("FAIL b2b_drain%0d got %h (present=%b) want %h", i, d, got, 8'(i));
            end
        end
        wait_clks(2);
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_empty got valid=%b want 0", m_valid);
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_break;
        test_glitch;
        test_overrun;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
